// File: rtl/duty_button_conditioner_pkg.sv
// ----------------------------------------------------------------------------
// duty_btn_pkg
// Shared types and default constants for the duty-control button conditioner.
//   btn_state_t  : per-button debounce FSM state
//   DEF_*        : default parameter values used by the top and the debouncer
//   max3()       : elaboration-time helper for sizing the shared counter
// ----------------------------------------------------------------------------
package duty_btn_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ARMING    = 2'd1,
      PRESSED   = 2'd2,
      RELEASING = 2'd3
   } btn_state_t;

   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 4;
   localparam int DEF_REPEAT_DELAY    = 50;
   localparam int DEF_REPEAT_PERIOD   = 20;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/duty_button_conditioner_debounce.sv
// ----------------------------------------------------------------------------
// button_debounce
// One button channel: synchroniser chain, debounce FSM with a shared
// up/down counter, and (with DUTY_BTN_AUTOREPEAT_EN) an auto-repeat timer.
//
// Ports
//   clk          : system clock, rising edge
//   rst          : synchronous reset, active high
//   i_raw        : raw asynchronous button level
//   o_press_req  : registered one-cycle request for a step pulse
//   o_held       : debounced button level (PRESSED or RELEASING)
//
// Optional feature macro: DUTY_BTN_AUTOREPEAT_EN
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | button released; first synchronised high starts arming
// ARMING    | counting consecutive highs; any low aborts back to IDLE
// PRESSED   | press accepted; counter is the repeat timer when enabled
// RELEASING | counting consecutive lows; any high returns to PRESSED
// ----------------------------------------------------------------------------
module button_debounce
   import duty_btn_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw,
   output logic o_press_req,
   output logic o_held
);

   localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   // The sample that moves IDLE->ARMING or PRESSED->RELEASING already
   // counts as the first one, so the terminal value is DEBOUNCE_CYCLES-1.
   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef DUTY_BTN_AUTOREPEAT_EN
   // Repeat timer counts down in PRESSED and fires on reaching zero, so
   // loading N-1 gives a pulse exactly N cycles after the previous one.
   localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_PERIOD - 1);
`else
   localparam logic [CNT_W-1:0] RPT_FIRST = CNT_ZERO;
`endif

   logic [SYNC_STAGES-1:0] r_sync;
   btn_state_t             r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_press_req;
   logic                   w_sync;

   assign w_sync      = r_sync[SYNC_STAGES-1];
   assign o_press_req = r_press_req;
   assign o_held      = (r_state == PRESSED) || (r_state == RELEASING);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync      <= '0;
         r_state     <= IDLE;
         r_cnt       <= CNT_ZERO;
         r_press_req <= 1'b0;
      end else begin
         r_sync      <= {r_sync[SYNC_STAGES-2:0], i_raw};
         r_press_req <= 1'b0;

         case (r_state)
            IDLE: begin
               if (w_sync) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     r_state     <= PRESSED;
                     r_press_req <= 1'b1;
                     r_cnt       <= RPT_FIRST;
                  end else begin
                     r_state <= ARMING;
                     r_cnt   <= CNT_ONE;
                  end
               end else begin
                  r_cnt <= CNT_ZERO;
               end
            end

            ARMING: begin
               if (!w_sync) begin
                  r_state <= IDLE;
                  r_cnt   <= CNT_ZERO;
               end else if (r_cnt == DB_LAST) begin
                  r_state     <= PRESSED;
                  r_press_req <= 1'b1;
                  r_cnt       <= RPT_FIRST;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end

            PRESSED: begin
               if (!w_sync) begin
                  // Leaving PRESSED reloads the counter for release
                  // qualification, which also cancels any repeat timing.
                  if (DEBOUNCE_CYCLES == 1) begin
                     r_state <= IDLE;
                     r_cnt   <= CNT_ZERO;
                  end else begin
                     r_state <= RELEASING;
                     r_cnt   <= CNT_ONE;
                  end
               end else begin
`ifdef DUTY_BTN_AUTOREPEAT_EN
                  if (r_cnt == CNT_ZERO) begin
                     r_press_req <= 1'b1;
                     r_cnt       <= RPT_NEXT;
                  end else begin
                     r_cnt <= r_cnt - CNT_ONE;
                  end
`else
                  r_cnt <= CNT_ZERO;
`endif
               end
            end

            RELEASING: begin
               if (w_sync) begin
                  // Release bounce: back to PRESSED, no new pulse, full
                  // repeat delay restarts.
                  r_state <= PRESSED;
                  r_cnt   <= RPT_FIRST;
               end else if (r_cnt == DB_LAST) begin
                  r_state <= IDLE;
                  r_cnt   <= CNT_ZERO;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end

            default: begin
               r_state <= IDLE;
               r_cnt   <= CNT_ZERO;
            end
         endcase
      end
   end

endmodule

// File: rtl/duty_button_conditioner.sv
// ----------------------------------------------------------------------------
// duty_button_conditioner
// Input stage for the PWM generator: conditions the raw increase/decrease
// duty buttons into single-cycle step pulses plus debounced held levels.
//
// Ports
//   clk               : system clock, rising edge
//   rst               : synchronous reset, active high
//   ui_increase_duty  : raw asynchronous increase button
//   ui_decrease_duty  : raw asynchronous decrease button
//   uo_inc_pulse      : one-cycle increase step
//   uo_dec_pulse      : one-cycle decrease step
//   uo_inc_held       : debounced increase button level
//   uo_dec_held       : debounced decrease button level
//
// Optional feature macro: DUTY_BTN_AUTOREPEAT_EN (auto-repeat while held)
// ----------------------------------------------------------------------------
module duty_button_conditioner
   import duty_btn_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst,
   input  logic ui_increase_duty,
   input  logic ui_decrease_duty,
   output logic uo_inc_pulse,
   output logic uo_dec_pulse,
   output logic uo_inc_held,
   output logic uo_dec_held
);

   logic w_inc_req;
   logic w_dec_req;
   logic w_inc_held;
   logic w_dec_held;

   button_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
   ) u_inc (
      .clk         (clk),
      .rst         (rst),
      .i_raw       (ui_increase_duty),
      .o_press_req (w_inc_req),
      .o_held      (w_inc_held)
   );

   button_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
   ) u_dec (
      .clk         (clk),
      .rst         (rst),
      .i_raw       (ui_decrease_duty),
      .o_press_req (w_dec_req),
      .o_held      (w_dec_held)
   );

   // Simultaneous requests cancel each other so the PWM never sees a
   // conflicting inc+dec step. The own-channel feedback term guarantees a
   // pulse is never two cycles wide even with a one-cycle repeat period.
   always_ff @(posedge clk) begin
      if (rst) begin
         uo_inc_pulse <= 1'b0;
         uo_dec_pulse <= 1'b0;
         uo_inc_held  <= 1'b0;
         uo_dec_held  <= 1'b0;
      end else begin
         uo_inc_pulse <= w_inc_req & ~w_dec_req & ~uo_inc_pulse;
         uo_dec_pulse <= w_dec_req & ~w_inc_req & ~uo_dec_pulse;
         uo_inc_held  <= w_inc_held;
         uo_dec_held  <= w_dec_held;
      end
   end

endmodule

// File: tb/tb_duty_button_conditioner.sv
// ----------------------------------------------------------------------------
// tb_duty_button_conditioner
// Directed bench for duty_button_conditioner with default parameters.
// Inputs change 1 ns after a rising edge, so the next edge (E0) samples them;
// expected pulse/held edges are E0 + SYNC_STAGES + DEBOUNCE_CYCLES = E0 + 6.
// ----------------------------------------------------------------------------
module tb_duty_button_conditioner;

   logic clk;
   logic rst;
   logic ui_increase_duty;
   logic ui_decrease_duty;
   logic uo_inc_pulse;
   logic uo_dec_pulse;
   logic uo_inc_held;
   logic uo_dec_held;

   int checks;
   int errors;
   int edge_cnt;
   int dbl_cnt;

   int inc_q[$];
   int dec_q[$];
   int ih_rise_q[$];
   int ih_fall_q[$];
   int dh_rise_q[$];
   int dh_fall_q[$];

   logic prev_inc, prev_dec, prev_ih, prev_dh;

   duty_button_conditioner dut (
      .clk              (clk),
      .rst              (rst),
      .ui_increase_duty (ui_increase_duty),
      .ui_decrease_duty (ui_decrease_duty),
      .uo_inc_pulse     (uo_inc_pulse),
      .uo_dec_pulse     (uo_dec_pulse),
      .uo_inc_held      (uo_inc_held),
      .uo_dec_held      (uo_dec_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial edge_cnt = 0;
   always @(posedge clk) edge_cnt = edge_cnt + 1;

   // Event recorder: logs the edge number after which each event is visible.
   initial begin
      dbl_cnt = 0;
      prev_inc = 1'b0; prev_dec = 1'b0; prev_ih = 1'b0; prev_dh = 1'b0;
   end
   always @(negedge clk) begin
      if (uo_inc_pulse === 1'b1) inc_q.push_back(edge_cnt);
      if (uo_dec_pulse === 1'b1) dec_q.push_back(edge_cnt);
      if (uo_inc_pulse === 1'b1 && prev_inc === 1'b1) dbl_cnt = dbl_cnt + 1;
      if (uo_dec_pulse === 1'b1 && prev_dec === 1'b1) dbl_cnt = dbl_cnt + 1;
      if (uo_inc_held === 1'b1 && prev_ih === 1'b0) ih_rise_q.push_back(edge_cnt);
      if (uo_inc_held === 1'b0 && prev_ih === 1'b1) ih_fall_q.push_back(edge_cnt);
      if (uo_dec_held === 1'b1 && prev_dh === 1'b0) dh_rise_q.push_back(edge_cnt);
      if (uo_dec_held === 1'b0 && prev_dh === 1'b1) dh_fall_q.push_back(edge_cnt);
      prev_inc = uo_inc_pulse;
      prev_dec = uo_dec_pulse;
      prev_ih  = uo_inc_held;
      prev_dh  = uo_dec_held;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      inc_q.delete();
      dec_q.delete();
      ih_rise_q.delete();
      ih_fall_q.delete();
      dh_rise_q.delete();
      dh_fall_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ui_increase_duty = 1'b0;
      ui_decrease_duty = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if ({uo_inc_pulse, uo_dec_pulse, uo_inc_held, uo_dec_held} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs cycle %0d: got %b expected 0000", i,
                     {uo_inc_pulse, uo_dec_pulse, uo_inc_held, uo_dec_held});
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(5);
   endtask

   task automatic test_clean_press();
      int e0;
      clear_logs();
      e0 = edge_cnt + 1;
      ui_increase_duty = 1'b1;
      step(10);
      ui_increase_duty = 1'b0;
      step(20);
      checks++;
      if (inc_q.size() != 1) begin
         errors++;
         $display("FAIL clean_inc_count: got %0d expected 1", inc_q.size());
      end
      checks++;
      if ((inc_q.size() > 0 ? inc_q[0] : -1) != e0 + 6) begin
         errors++;
         $display("FAIL clean_inc_edge: got %0d expected %0d",
                  (inc_q.size() > 0 ? inc_q[0] : -1), e0 + 6);
      end
      checks++;
      if (dec_q.size() != 0) begin
         errors++;
         $display("FAIL clean_dec_quiet: got %0d pulses expected 0", dec_q.size());
      end
      checks++;
      if ((ih_rise_q.size() > 0 ? ih_rise_q[0] : -1) != e0 + 6) begin
         errors++;
         $display("FAIL clean_held_rise: got %0d expected %0d",
                  (ih_rise_q.size() > 0 ? ih_rise_q[0] : -1), e0 + 6);
      end
      checks++;
      if ((ih_fall_q.size() > 0 ? ih_fall_q[0] : -1) != e0 + 16) begin
         errors++;
         $display("FAIL clean_held_fall: got %0d expected %0d",
                  (ih_fall_q.size() > 0 ? ih_fall_q[0] : -1), e0 + 16);
      end
   endtask

   task automatic test_bounce_reject();
      clear_logs();
      ui_decrease_duty = 1'b1; step(1);
      ui_decrease_duty = 1'b0; step(1);
      ui_decrease_duty = 1'b1; step(1);
      ui_decrease_duty = 1'b0; step(20);
      checks++;
      if (dec_q.size() != 0) begin
         errors++;
         $display("FAIL bounce_dec_pulse: got %0d pulses expected 0", dec_q.size());
      end
      checks++;
      if (dh_rise_q.size() != 0) begin
         errors++;
         $display("FAIL bounce_dec_held: got %0d rises expected 0", dh_rise_q.size());
      end
   endtask

   task automatic test_min_press();
      int e0;
      clear_logs();
      // DEBOUNCE_CYCLES-1 high samples: rejected.
      ui_increase_duty = 1'b1; step(3);
      ui_increase_duty = 1'b0; step(15);
      checks++;
      if (inc_q.size() != 0 || ih_rise_q.size() != 0) begin
         errors++;
         $display("FAIL short_press: got %0d pulses %0d rises expected 0 0",
                  inc_q.size(), ih_rise_q.size());
      end
      // Exactly DEBOUNCE_CYCLES high samples: accepted.
      clear_logs();
      e0 = edge_cnt + 1;
      ui_increase_duty = 1'b1; step(4);
      ui_increase_duty = 1'b0; step(20);
      checks++;
      if (inc_q.size() != 1 || (inc_q.size() > 0 ? inc_q[0] : -1) != e0 + 6) begin
         errors++;
         $display("FAIL min_press_pulse: got count %0d edge %0d expected 1 at %0d",
                  inc_q.size(), (inc_q.size() > 0 ? inc_q[0] : -1), e0 + 6);
      end
      checks++;
      if ((ih_fall_q.size() > 0 ? ih_fall_q[0] : -1) != e0 + 10) begin
         errors++;
         $display("FAIL min_press_fall: got %0d expected %0d",
                  (ih_fall_q.size() > 0 ? ih_fall_q[0] : -1), e0 + 10);
      end
   endtask

   task automatic test_release_bounce();
      int e0;
      clear_logs();
      e0 = edge_cnt + 1;
      ui_increase_duty = 1'b1; step(10);
      ui_increase_duty = 1'b0; step(3);
      ui_increase_duty = 1'b1; step(10);
      ui_increase_duty = 1'b0; step(20);
      checks++;
      if (inc_q.size() != 1) begin
         errors++;
         $display("FAIL relbounce_count: got %0d expected 1", inc_q.size());
      end
      checks++;
      if (ih_rise_q.size() != 1 || ih_fall_q.size() != 1) begin
         errors++;
         $display("FAIL relbounce_held_edges: got %0d rises %0d falls expected 1 1",
                  ih_rise_q.size(), ih_fall_q.size());
      end
      checks++;
      if ((ih_fall_q.size() > 0 ? ih_fall_q[0] : -1) != e0 + 29) begin
         errors++;
         $display("FAIL relbounce_fall: got %0d expected %0d",
                  (ih_fall_q.size() > 0 ? ih_fall_q[0] : -1), e0 + 29);
      end
   endtask

   task automatic test_three_steps();
      int e0;
      clear_logs();
      e0 = edge_cnt + 1;
      for (int k = 0; k < 3; k++) begin
         ui_increase_duty = 1'b1; step(10);
         ui_increase_duty = 1'b0; step(10);
      end
      for (int k = 0; k < 3; k++) begin
         ui_decrease_duty = 1'b1; step(10);
         ui_decrease_duty = 1'b0; step(10);
      end
      step(10);
      checks++;
      if (inc_q.size() != 3 || dec_q.size() != 3) begin
         errors++;
         $display("FAIL steps_count: got inc %0d dec %0d expected 3 3",
                  inc_q.size(), dec_q.size());
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ((inc_q.size() > k ? inc_q[k] : -1) != e0 + 20 * k + 6) begin
            errors++;
            $display("FAIL steps_inc_edge%0d: got %0d expected %0d", k,
                     (inc_q.size() > k ? inc_q[k] : -1), e0 + 20 * k + 6);
         end
         checks++;
         if ((dec_q.size() > k ? dec_q[k] : -1) != e0 + 60 + 20 * k + 6) begin
            errors++;
            $display("FAIL steps_dec_edge%0d: got %0d expected %0d", k,
                     (dec_q.size() > k ? dec_q[k] : -1), e0 + 60 + 20 * k + 6);
         end
      end
   endtask

   task automatic test_simultaneous();
      int e0;
      clear_logs();
      e0 = edge_cnt + 1;
      ui_increase_duty = 1'b1;
      ui_decrease_duty = 1'b1;
      step(10);
      ui_increase_duty = 1'b0;
      ui_decrease_duty = 1'b0;
      step(20);
      checks++;
      if (inc_q.size() != 0 || dec_q.size() != 0) begin
         errors++;
         $display("FAIL simul_suppress: got inc %0d dec %0d expected 0 0",
                  inc_q.size(), dec_q.size());
      end
      checks++;
      if ((ih_rise_q.size() > 0 ? ih_rise_q[0] : -1) != e0 + 6 ||
          (dh_rise_q.size() > 0 ? dh_rise_q[0] : -1) != e0 + 6) begin
         errors++;
         $display("FAIL simul_held: got inc %0d dec %0d expected %0d",
                  (ih_rise_q.size() > 0 ? ih_rise_q[0] : -1),
                  (dh_rise_q.size() > 0 ? dh_rise_q[0] : -1), e0 + 6);
      end
   endtask

   task automatic test_reset_mid_press();
      int e0;
      clear_logs();
      e0 = edge_cnt + 1;
      ui_increase_duty = 1'b1;
      step(4);
      rst = 1'b1;
      step(3);
      rst = 1'b0;
      step(14);
      ui_increase_duty = 1'b0;
      step(20);
      checks++;
      if (inc_q.size() != 1 || (inc_q.size() > 0 ? inc_q[0] : -1) != e0 + 13) begin
         errors++;
         $display("FAIL rstmid_pulse: got count %0d edge %0d expected 1 at %0d",
                  inc_q.size(), (inc_q.size() > 0 ? inc_q[0] : -1), e0 + 13);
      end
      checks++;
      if ((ih_rise_q.size() > 0 ? ih_rise_q[0] : -1) != e0 + 13) begin
         errors++;
         $display("FAIL rstmid_held: got %0d expected %0d",
                  (ih_rise_q.size() > 0 ? ih_rise_q[0] : -1), e0 + 13);
      end
   endtask

`ifdef DUTY_BTN_AUTOREPEAT_EN
   task automatic test_autorepeat();
      int e0;
      int exp_edges[5];
      clear_logs();
      exp_edges = '{6, 56, 76, 96, 116};
      e0 = edge_cnt + 1;
      ui_increase_duty = 1'b1; step(120);
      ui_increase_duty = 1'b0; step(40);
      checks++;
      if (inc_q.size() != 5) begin
         errors++;
         $display("FAIL repeat_count: got %0d expected 5", inc_q.size());
      end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if ((inc_q.size() > k ? inc_q[k] : -1) != e0 + exp_edges[k]) begin
            errors++;
            $display("FAIL repeat_edge%0d: got %0d expected %0d", k,
                     (inc_q.size() > k ? inc_q[k] : -1), e0 + exp_edges[k]);
         end
      end
   endtask
`endif

   task automatic test_pulse_width();
      checks++;
      if (dbl_cnt != 0) begin
         errors++;
         $display("FAIL pulse_width: got %0d wide pulses expected 0", dbl_cnt);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_clean_press();
      test_bounce_reject();
      test_min_press();
      test_release_bounce();
      test_three_steps();
      test_simultaneous();
      test_reset_mid_press();
`ifdef DUTY_BTN_AUTOREPEAT_EN
      test_autorepeat();
`endif
      test_pulse_width();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
